// File: rtl/key_evt_pkg.sv
// Shared definitions for the key event controller: event encodings, the
// event record and a width helper.
package key_evt_pkg;

   typedef enum logic [1:0] {
      EVT_PRESS   = 2'b00,
      EVT_RELEASE = 2'b01,
      EVT_LONG    = 2'b10
   } evt_type_e;

   // Wide enough for the largest supported key count (16)
   localparam int KEY_IDX_W_MAX = 4;

   typedef struct packed {
      logic [KEY_IDX_W_MAX-1:0] key;
      evt_type_e                kind;
   } key_evt_t;

   function automatic int width_of(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_event_ctrl_channel.sv
// One key: 2-flop synchronizer, debounce, long-press timer and a
// single-entry pending event slot handed to the shared arbiter.
module key_channel
   import key_evt_pkg::*;
#(
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int LONG_CYCLES     = 24000000
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      key_in,
   input  logic      grant,
   output logic      key_state,
   output logic      pending_valid,
   output evt_type_e pending_type,
   output logic      drop
);

   localparam int DW = width_of(DEBOUNCE_CYCLES);
   localparam int LW = width_of(LONG_CYCLES);
   localparam logic IDLE_LEVEL = ACTIVE_LOW ? 1'b1 : 1'b0;
   localparam logic [DW-1:0] DCNT_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [LW-1:0] LCNT_LAST = LW'(LONG_CYCLES - 1);

   logic            sync1_reg, sync2_reg;
   logic            synced;
   logic [DW-1:0]   dcnt_reg, dcnt_next;
   logic            state_reg, state_next, state_prev_reg;
   logic [LW-1:0]   lcnt_reg, lcnt_next;
   logic            long_done_reg, long_done_next;
   logic            pend_valid_reg, pend_valid_next;
   evt_type_e       pend_type_reg, pend_type_next;
   logic            edge_evt, long_fire, new_evt;
   evt_type_e       new_type;

   assign synced = sync2_reg ^ IDLE_LEVEL;

   always_comb begin
      dcnt_next  = '0;
      state_next = state_reg;
      if (synced != state_reg) begin
         if (dcnt_reg == DCNT_LAST) begin
            state_next = ~state_reg;
         end else begin
            dcnt_next = dcnt_reg + 1'b1;
         end
      end

      // Counter saturates at its last value; long_done keeps LONG one-shot
      lcnt_next      = lcnt_reg;
      long_done_next = long_done_reg;
      long_fire      = 1'b0;
      if (!state_reg) begin
         lcnt_next      = '0;
         long_done_next = 1'b0;
      end else if (lcnt_reg == LCNT_LAST) begin
         if (!long_done_reg) begin
            long_fire      = 1'b1;
            long_done_next = 1'b1;
         end
      end else begin
         lcnt_next = lcnt_reg + 1'b1;
      end

      edge_evt = state_reg ^ state_prev_reg;
      new_evt  = edge_evt | long_fire;
      if (edge_evt) begin
         new_type = state_reg ? EVT_PRESS : EVT_RELEASE;
      end else begin
         new_type = EVT_LONG;
      end

      // A grant frees the slot in the same cycle, so a coincident event reloads it
      pend_valid_next = pend_valid_reg;
      pend_type_next  = pend_type_reg;
      drop            = 1'b0;
      if (grant) begin
         pend_valid_next = 1'b0;
      end
      if (new_evt) begin
         if (pend_valid_reg && !grant) begin
            drop = 1'b1;
         end else begin
            pend_valid_next = 1'b1;
            pend_type_next  = new_type;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_reg      <= IDLE_LEVEL;
         sync2_reg      <= IDLE_LEVEL;
         dcnt_reg       <= '0;
         state_reg      <= 1'b0;
         state_prev_reg <= 1'b0;
         lcnt_reg       <= '0;
         long_done_reg  <= 1'b0;
         pend_valid_reg <= 1'b0;
         pend_type_reg  <= EVT_PRESS;
      end else begin
         sync1_reg      <= key_in;
         sync2_reg      <= sync1_reg;
         dcnt_reg       <= dcnt_next;
         state_reg      <= state_next;
         state_prev_reg <= state_reg;
         lcnt_reg       <= lcnt_next;
         long_done_reg  <= long_done_next;
         pend_valid_reg <= pend_valid_next;
         pend_type_reg  <= pend_type_next;
      end
   end

   assign key_state     = state_reg;
   assign pending_valid = pend_valid_reg;
   assign pending_type  = pend_type_reg;

endmodule

// File: rtl/key_event_ctrl.sv
// Multi-key push-button controller: per-key channels feed a round-robin
// arbiter that fills a shared event FIFO read over a valid/ready stream.
module key_event_ctrl
   import key_evt_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter bit ACTIVE_LOW      = 1'b1,
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int LONG_CYCLES     = 24000000,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [NUM_KEYS-1:0]         key_in,
   output logic [NUM_KEYS-1:0]         key_state,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [$clog2(NUM_KEYS)-1:0] evt_key,
   output logic [1:0]                  evt_type,
   output logic                        overflow,
   input  logic                        clr_overflow
);

   localparam int KW = $clog2(NUM_KEYS);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = KW + 2;
   localparam logic [KW:0]   NK_W     = (KW + 1)'(NUM_KEYS);
   localparam logic [KW-1:0] LAST_KEY = KW'(NUM_KEYS - 1);

   logic [NUM_KEYS-1:0]      pend_valid, grant, drop;
   logic [NUM_KEYS-1:0][1:0] pend_type;

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
         key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .LONG_CYCLES     (LONG_CYCLES)
         ) u_chan (
            .clk           (clk),
            .reset         (reset),
            .key_in        (key_in[gi]),
            .grant         (grant[gi]),
            .key_state     (key_state[gi]),
            .pending_valid (pend_valid[gi]),
            .pending_type  (pend_type[gi]),
            .drop          (drop[gi])
         );
      end
   endgenerate

   logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
   logic [EW-1:0] fifo_mem [FIFO_DEPTH];
   logic          empty, full, pop, fifo_accept;

   assign empty       = (wr_ptr_reg == rd_ptr_reg);
   assign full        = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                        (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
   assign evt_valid   = !empty;
   assign pop         = evt_valid && evt_ready;
   assign fifo_accept = !full || pop;

   logic [KW-1:0] arb_ptr_reg, arb_ptr_next, gnt_idx;
   logic [KW:0]   cand;
   logic          gnt_any;
   logic [EW-1:0] wr_word;

   // First pending key at or after the pointer, wrapping past the last key
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      cand    = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         cand = {1'b0, arb_ptr_reg} + (KW + 1)'(i);
         if (cand >= NK_W) begin
            cand = cand - NK_W;
         end
         if (!gnt_any && fifo_accept && pend_valid[cand[KW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = cand[KW-1:0];
         end
      end

      arb_ptr_next = arb_ptr_reg;
      if (gnt_any) begin
         arb_ptr_next = (gnt_idx == LAST_KEY) ? '0 : gnt_idx + 1'b1;
      end

      wr_word = {gnt_idx, pend_type[gnt_idx]};
   end

   generate
      for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_grant
         assign grant[gi] = gnt_any && (gnt_idx == KW'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (gnt_any) begin
         fifo_mem[wr_ptr_reg[AW-1:0]] <= wr_word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         arb_ptr_reg  <= '0;
         overflow     <= 1'b0;
      end else begin
         if (gnt_any) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         arb_ptr_reg <= arb_ptr_next;
         // A loss in the same cycle as a clear keeps the flag set
         if (|drop) begin
            overflow <= 1'b1;
         end else if (clr_overflow) begin
            overflow <= 1'b0;
         end
      end
   end

   assign evt_key  = fifo_mem[rd_ptr_reg[AW-1:0]][EW-1:2];
   assign evt_type = fifo_mem[rd_ptr_reg[AW-1:0]][1:0];

endmodule

// File: tb/tb_key_event_ctrl.sv
// Self-checking bench for key_event_ctrl: table-driven press vectors plus
// hand-written arbitration, backpressure, overflow and reset sequences.
module tb_key_event_ctrl;
   import key_evt_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] key_in = 4'hF;
   logic [3:0] key_state;
   logic       evt_valid;
   logic       evt_ready = 1'b1;
   logic [1:0] evt_key;
   logic [1:0] evt_type;
   logic       overflow;
   logic       clr_overflow = 1'b0;

   always #5 clk = ~clk;

   key_event_ctrl #(
      .NUM_KEYS        (4),
      .ACTIVE_LOW      (1'b1),
      .DEBOUNCE_CYCLES (4),
      .LONG_CYCLES     (20),
      .FIFO_DEPTH      (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .key_in       (key_in),
      .key_state    (key_state),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_key      (evt_key),
      .evt_type     (evt_type),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   typedef struct {
      int key;
      int low_cycles;
      int exp_high;
      bit exp_long;
   } vec_t;

   key_evt_t sb_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp_v, $time);
      end else begin
         $display("ok   %s = %0d", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input int k, input evt_type_e t);
      sb_q.push_back('{key: 4'(k), kind: t});
   endtask

   task automatic monitor();
      key_evt_t e;
      forever begin
         @(negedge clk);
         if (!reset && evt_valid && evt_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_evt actual key=%0d type=%0d required none", evt_key, evt_type);
            end else begin
               e = sb_q.pop_front();
               $display("evt  key=%0d type=%0d", evt_key, evt_type);
               check("evt_key", 32'(evt_key), 32'(e.key));
               check("evt_type", 32'(evt_type), 32'(e.kind));
            end
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      sb_q.delete();
   endtask

   task automatic run_vec(input vec_t v);
      int high;
      high = 0;
      if (v.exp_high > 0) begin
         expect_evt(v.key, EVT_PRESS);
         if (v.exp_long) expect_evt(v.key, EVT_LONG);
         expect_evt(v.key, EVT_RELEASE);
      end
      key_in[v.key] = 1'b0;
      for (int i = 0; i < v.low_cycles; i++) begin
         tick();
         if (key_state[v.key]) high++;
      end
      key_in[v.key] = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (key_state[v.key]) high++;
      end
      check("vec_high_cycles", high, v.exp_high);
      check("vec_sb_drained", sb_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [8];
      int   bad, ks_c, ev_c;
      logic [1:0] head_key, head_type;

      vecs[0] = '{1, 3, 0, 1'b0};
      vecs[1] = '{1, 10, 10, 1'b0};
      vecs[2] = '{0, 4, 4, 1'b0};
      vecs[3] = '{3, 1, 0, 1'b0};
      vecs[4] = '{2, 19, 19, 1'b0};
      vecs[5] = '{2, 20, 20, 1'b1};
      vecs[6] = '{2, 40, 40, 1'b1};
      vecs[7] = '{0, 5, 5, 1'b0};

      fork
         monitor();
      join_none

      // Reset state and 50 idle cycles
      tick();
      check("rst_evt_valid", evt_valid, 0);
      check("rst_key_state", key_state, 0);
      reset = 1'b0;
      check("rst_overflow", overflow, 0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (key_state != 4'h0 || evt_valid) bad++;
      end
      check("idle_50_cycles", bad, 0);

      for (int i = 0; i < 8; i++) begin
         run_vec(vecs[i]);
      end

      // key_state visible at T+1, evt_valid at T+3
      ks_c = -1;
      ev_c = -1;
      expect_evt(1, EVT_PRESS);
      expect_evt(1, EVT_RELEASE);
      key_in[1] = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (i == 10) key_in[1] = 1'b1;
         tick();
         if (key_state[1] && ks_c < 0) ks_c = i;
         if (evt_valid && ev_c < 0) ev_c = i;
      end
      check("lat_key_state_seen", ks_c >= 0, 1);
      check("lat_state_to_valid", ev_c - ks_c, 2);
      check("lat_sb_drained", sb_q.size(), 0);

      // Simultaneous keys 0 and 3 with pointer at 0
      do_reset();
      check("simul_ptr_start", 32'(dut.arb_ptr_reg), 0);
      expect_evt(0, EVT_PRESS);
      expect_evt(3, EVT_PRESS);
      expect_evt(0, EVT_RELEASE);
      expect_evt(3, EVT_RELEASE);
      key_in = 4'b0110;
      repeat (11) tick();
      check("simul_ptr_end", 32'(dut.arb_ptr_reg), 0);
      check("simul_press_popped", sb_q.size(), 2);
      key_in = 4'hF;
      repeat (20) tick();
      check("simul_sb_drained", sb_q.size(), 0);

      // Backpressure: FIFO full, one key waiting, one released event waiting
      do_reset();
      evt_ready = 1'b0;
      expect_evt(0, EVT_PRESS);
      expect_evt(1, EVT_PRESS);
      expect_evt(2, EVT_PRESS);
      expect_evt(0, EVT_RELEASE);
      expect_evt(1, EVT_LONG);
      expect_evt(2, EVT_LONG);
      expect_evt(1, EVT_RELEASE);
      expect_evt(2, EVT_RELEASE);
      key_in = 4'b1000;
      repeat (6) tick();
      key_in[0] = 1'b1;
      repeat (10) tick();
      check("bp_overflow", overflow, 0);
      check("bp_evt_valid", evt_valid, 1);
      check("bp_head_key", evt_key, 0);
      check("bp_head_type", evt_type, 32'(EVT_PRESS));
      check("bp_key_state", key_state, 4'b0110);
      check("bp_nothing_popped", sb_q.size(), 8);
      head_key  = evt_key;
      head_type = evt_type;
      tick();
      check("bp_head_key_stable", evt_key, head_key);
      check("bp_head_type_stable", evt_type, head_type);
      evt_ready = 1'b1;
      repeat (23) tick();
      key_in = 4'hF;
      repeat (20) tick();
      check("bp_overflow_after", overflow, 0);
      check("bp_sb_drained", sb_q.size(), 0);

      // Overflow: key 0 release lost while its press is still pending
      evt_ready = 1'b0;
      key_in = 4'b1001;
      repeat (5) tick();
      key_in = 4'hF;
      repeat (9) tick();
      key_in[0] = 1'b0;
      repeat (5) tick();
      key_in[0] = 1'b1;
      repeat (11) tick();
      check("ovf_set", overflow, 1);
      check("ovf_head_key", evt_key, 1);
      clr_overflow = 1'b1;
      tick();
      clr_overflow = 1'b0;
      check("ovf_cleared", overflow, 0);
      check("ovf_valid_before_rst", evt_valid, 1);
      reset = 1'b1;
      #2;
      check("async_rst_evt_valid", evt_valid, 0);
      tick();
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (evt_valid || key_state != 4'h0) bad++;
      end
      check("post_rst_empty", bad, 0);
      check("final_sb_empty", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
